// File: rtl/err_recover_seq.sv
// Slice-serial error recovery: rebuilds sum + 2*err one SLICE per cycle,
// with valid/ready handshakes on both sides and a zero-error bypass.
module err_recover_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             out_ovf,
  output logic             out_fast
);

  localparam int NS = WIDTH / SLICE;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] e_reg;
  logic             emsb_reg;
  logic             c_reg;
  logic [KW-1:0]    k_reg;

  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] a_next;
  int               base;

  // One slice of the carry chain; a_next is the accumulator with slice k replaced.
  always_comb begin
    base      = int'(k_reg) * SLICE;
    slice_sum = {1'b0, a_reg[base +: SLICE]} + {1'b0, e_reg[base +: SLICE]}
                + {{SLICE{1'b0}}, c_reg};
    a_next    = a_reg;
    a_next[base +: SLICE] = slice_sum[SLICE-1:0];
  end

  assign in_ready = (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      e_reg     <= '0;
      emsb_reg  <= 1'b0;
      c_reg     <= 1'b0;
      k_reg     <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_ovf   <= 1'b0;
      out_fast  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_sum;
            e_reg    <= {in_err[WIDTH-2:0], 1'b0};
            emsb_reg <= in_err[WIDTH-1];
            c_reg    <= 1'b0;
            k_reg    <= '0;
            if (in_err == '0) begin
              out_prod  <= in_sum;
              out_ovf   <= 1'b0;
              out_fast  <= 1'b1;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              out_fast  <= 1'b0;
              state_reg <= ADD;
            end
          end
        end
        ADD: begin
          a_reg <= a_next;
          c_reg <= slice_sum[SLICE];
          k_reg <= k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            // The shifted-out error MSB carries weight 2^WIDTH, so it only feeds overflow.
            out_prod  <= a_next;
            out_ovf   <= slice_sum[SLICE] | emsb_reg;
            out_valid <= 1'b1;
            k_reg     <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
